// File: rtl/mb_addr_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : mb_addr_select
// | Description : Chooses the MAC/IP for the Ethernet stack, taking the MCU's
// |               addresses when valid and falling back to defaults on timeout.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module mb_addr_select #(
  parameter logic [47:0] DEFAULT_MAC    = 48'h001CC0A2225D,
  parameter logic [31:0] DEFAULT_IP     = 32'h00000000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd122880000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [47:0] mac_in,
  input  logic [31:0] ip_in,
  input  logic        addr_read,
  output logic [47:0] mac_out,
  output logic [31:0] ip_out,
  output logic        static_ip,
  output logic        locked,
  output logic        mac_from_mcu,
  output logic        ip_from_mcu,
  output logic        timed_out
);

  localparam logic [2:0] c_st_wait           = 3'd0;
  localparam logic [2:0] c_st_capture        = 3'd1;
  localparam logic [2:0] c_st_check          = 3'd2;
  localparam logic [2:0] c_st_locked_default = 3'd3;
  localparam logic [2:0] c_st_locked_mcu     = 3'd4;

  localparam logic [31:0] c_timeout_last = TIMEOUT_CYCLES - 32'd1;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic [47:0] r_mac_shadow;
  logic [47:0] w_mac_shadow_next;
  logic [31:0] r_ip_shadow;
  logic [31:0] w_ip_shadow_next;

  logic [47:0] r_mac_out;
  logic [47:0] w_mac_out_next;
  logic [31:0] r_ip_out;
  logic [31:0] w_ip_out_next;
  logic        r_static_ip;
  logic        w_static_ip_next;
  logic        r_locked;
  logic        w_locked_next;
  logic        r_mac_from_mcu;
  logic        w_mac_from_mcu_next;
  logic        r_ip_from_mcu;
  logic        w_ip_from_mcu_next;
  logic        r_timed_out;
  logic        w_timed_out_next;

  logic [7:0]  w_ip_octet;
  logic        w_mac_valid;
  logic        w_ip_valid;
  logic        w_timeout_hit;

  // Bit 40 is the multicast bit of the first transmitted MAC octet.
  assign w_mac_valid   = (r_mac_shadow != 48'd0) && !r_mac_shadow[40];
  assign w_ip_octet    = r_ip_shadow[31:24];
  assign w_ip_valid    = (w_ip_octet != 8'd0) && (w_ip_octet != 8'd127) && (w_ip_octet < 8'd224);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (r_count == c_timeout_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_st_wait;
    end else begin
      r_state <= w_state_next;
    end
  end

  // addr_read wins over a coincident timeout terminal count.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_wait: begin
        if (addr_read) begin
          w_state_next = c_st_capture;
        end else if (w_timeout_hit) begin
          w_state_next = c_st_locked_default;
        end
      end
      c_st_capture:        w_state_next = c_st_check;
      c_st_check:          w_state_next = c_st_locked_mcu;
      c_st_locked_default: begin
        if (addr_read) begin
          w_state_next = c_st_capture;
        end
      end
      c_st_locked_mcu:     w_state_next = c_st_locked_mcu;
      default:             w_state_next = c_st_wait;
    endcase
  end

  always_comb begin
    w_count_next        = r_count;
    w_mac_shadow_next   = r_mac_shadow;
    w_ip_shadow_next    = r_ip_shadow;
    w_mac_out_next      = r_mac_out;
    w_ip_out_next       = r_ip_out;
    w_static_ip_next    = r_static_ip;
    w_locked_next       = r_locked;
    w_mac_from_mcu_next = r_mac_from_mcu;
    w_ip_from_mcu_next  = r_ip_from_mcu;
    w_timed_out_next    = r_timed_out;
    case (r_state)
      c_st_wait: begin
        if (!addr_read) begin
          if (w_timeout_hit) begin
            w_mac_out_next      = DEFAULT_MAC;
            w_ip_out_next       = DEFAULT_IP;
            w_static_ip_next    = 1'b0;
            w_mac_from_mcu_next = 1'b0;
            w_ip_from_mcu_next  = 1'b0;
            w_locked_next       = 1'b1;
            w_timed_out_next    = 1'b1;
          end else begin
            w_count_next = r_count + 32'd1;
          end
        end
      end
      c_st_capture: begin
        w_mac_shadow_next = mac_in;
        w_ip_shadow_next  = ip_in;
      end
      // timed_out is left alone so a late MCU update keeps the diagnostic.
      c_st_check: begin
        w_mac_out_next      = w_mac_valid ? r_mac_shadow : DEFAULT_MAC;
        w_ip_out_next       = w_ip_valid ? r_ip_shadow : DEFAULT_IP;
        w_static_ip_next    = w_ip_valid;
        w_ip_from_mcu_next  = w_ip_valid;
        w_mac_from_mcu_next = w_mac_valid;
        w_locked_next       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count        <= 32'd0;
      r_mac_shadow   <= 48'd0;
      r_ip_shadow    <= 32'd0;
      r_mac_out      <= DEFAULT_MAC;
      r_ip_out       <= DEFAULT_IP;
      r_static_ip    <= 1'b0;
      r_locked       <= 1'b0;
      r_mac_from_mcu <= 1'b0;
      r_ip_from_mcu  <= 1'b0;
      r_timed_out    <= 1'b0;
    end else begin
      r_count        <= w_count_next;
      r_mac_shadow   <= w_mac_shadow_next;
      r_ip_shadow    <= w_ip_shadow_next;
      r_mac_out      <= w_mac_out_next;
      r_ip_out       <= w_ip_out_next;
      r_static_ip    <= w_static_ip_next;
      r_locked       <= w_locked_next;
      r_mac_from_mcu <= w_mac_from_mcu_next;
      r_ip_from_mcu  <= w_ip_from_mcu_next;
      r_timed_out    <= w_timed_out_next;
    end
  end

  assign mac_out      = r_mac_out;
  assign ip_out       = r_ip_out;
  assign static_ip    = r_static_ip;
  assign locked       = r_locked;
  assign mac_from_mcu = r_mac_from_mcu;
  assign ip_from_mcu  = r_ip_from_mcu;
  assign timed_out    = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_mb_addr_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : tb_mb_addr_select
// | Description : Directed and randomized check of mb_addr_select against a
// |               timeline model, with a 16-cycle and a disabled timeout.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_mb_addr_select;

  localparam logic [47:0] DEF_MAC = 48'h001CC0A2225D;
  localparam logic [31:0] DEF_IP  = 32'h00000000;

  logic        clock;
  logic        reset;
  logic [47:0] mac_in;
  logic [31:0] ip_in;
  logic        addr_read;

  logic [47:0] mac_o   [2];
  logic [31:0] ip_o    [2];
  logic        stat_o  [2];
  logic        lock_o  [2];
  logic        macf_o  [2];
  logic        ipf_o   [2];
  logic        timed_o [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Instance 0 times out after 16 cycles; instance 1 never times out.
  mb_addr_select #(.TIMEOUT_CYCLES(32'd16)) u_dut16 (
    .clock(clock), .reset(reset), .mac_in(mac_in), .ip_in(ip_in), .addr_read(addr_read),
    .mac_out(mac_o[0]), .ip_out(ip_o[0]), .static_ip(stat_o[0]), .locked(lock_o[0]),
    .mac_from_mcu(macf_o[0]), .ip_from_mcu(ipf_o[0]), .timed_out(timed_o[0])
  );

  mb_addr_select #(.TIMEOUT_CYCLES(32'd0)) u_dut0 (
    .clock(clock), .reset(reset), .mac_in(mac_in), .ip_in(ip_in), .addr_read(addr_read),
    .mac_out(mac_o[1]), .ip_out(ip_o[1]), .static_ip(stat_o[1]), .locked(lock_o[1]),
    .mac_from_mcu(macf_o[1]), .ip_from_mcu(ipf_o[1]), .timed_out(timed_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: mode 0 = waiting, 1 = locked on defaults, 2 = locked on MCU values.
  // busy counts the edges left until a requested capture takes effect.
  int          t_cfg     [2];
  int          m_mode    [2];
  longint      m_elapsed [2];
  int          m_busy    [2];
  logic [47:0] m_smac    [2];
  logic [31:0] m_sip     [2];
  logic [47:0] e_mac     [2];
  logic [31:0] e_ip      [2];
  bit          e_stat    [2];
  bit          e_lock    [2];
  bit          e_macf    [2];
  bit          e_ipf     [2];
  bit          e_timed   [2];

  function automatic bit mac_ok(input logic [47:0] m);
    return (m != 48'd0) && (((m / 48'h010000000000) % 2) == 0);
  endfunction

  function automatic bit ip_ok(input logic [31:0] ip);
    int oct;
    oct = int'(ip / 32'h01000000);
    return (oct != 0) && (oct != 127) && (oct < 224);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_step(input int k);
    bit mv, iv;
    if (reset) begin
      m_mode[k] = 0; m_elapsed[k] = 0; m_busy[k] = 0;
      m_smac[k] = '0; m_sip[k] = '0;
      e_mac[k] = DEF_MAC; e_ip[k] = DEF_IP;
      e_stat[k] = 0; e_lock[k] = 0; e_macf[k] = 0; e_ipf[k] = 0; e_timed[k] = 0;
    end else if (m_busy[k] == 2) begin
      m_smac[k] = mac_in; m_sip[k] = ip_in; m_busy[k] = 1;
    end else if (m_busy[k] == 1) begin
      mv = mac_ok(m_smac[k]); iv = ip_ok(m_sip[k]);
      e_mac[k] = mv ? m_smac[k] : DEF_MAC;
      e_ip[k]  = iv ? m_sip[k] : DEF_IP;
      e_stat[k] = iv; e_ipf[k] = iv; e_macf[k] = mv; e_lock[k] = 1;
      m_mode[k] = 2; m_busy[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (addr_read) m_busy[k] = 2;
      else if (t_cfg[k] != 0 && m_elapsed[k] == longint'(t_cfg[k] - 1)) begin
        e_mac[k] = DEF_MAC; e_ip[k] = DEF_IP; e_stat[k] = 0;
        e_lock[k] = 1; e_timed[k] = 1; m_mode[k] = 1;
      end else m_elapsed[k]++;
    end else if (m_mode[k] == 1 && addr_read) begin
      m_busy[k] = 2;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.mac_out", k), mac_o[k], e_mac[k]);
      check($sformatf("u%0d.ip_out", k), ip_o[k], e_ip[k]);
      check($sformatf("u%0d.static_ip", k), stat_o[k], e_stat[k]);
      check($sformatf("u%0d.locked", k), lock_o[k], e_lock[k]);
      check($sformatf("u%0d.mac_from_mcu", k), macf_o[k], e_macf[k]);
      check($sformatf("u%0d.ip_from_mcu", k), ipf_o[k], e_ipf[k]);
      check($sformatf("u%0d.timed_out", k), timed_o[k], e_timed[k]);
    end
  endtask

  task automatic cycle(input bit r, input bit ar, input logic [47:0] m, input logic [31:0] i);
    @(negedge clock);
    reset = r; addr_read = ar; mac_in = m; ip_in = i;
    model_step(0);
    model_step(1);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(0, 0, mac_in, ip_in);
  endtask

  function automatic logic [47:0] pick_mac();
    logic [47:0] m;
    m = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: m[40] = 1'b0;
      1: m[40] = 1'b1;
      2: m = 48'd0;
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] pick_ip();
    logic [31:0] ip;
    ip = $urandom;
    case ($urandom_range(0, 5))
      0: ip[31:24] = 8'd0;
      1: ip[31:24] = 8'd127;
      2: ip[31:24] = 8'd223;
      3: ip[31:24] = 8'd224;
      4: ip[31:24] = 8'd1;
      default: ;
    endcase
    return ip;
  endfunction

  initial begin
    t_cfg[0] = 16; t_cfg[1] = 0;
    reset = 1'b1; addr_read = 1'b0; mac_in = '0; ip_in = '0;

    // Reset state and MCU-supplied valid addresses.
    cycle(1, 0, 48'd0, 32'd0);
    check("reset_locked", lock_o[0], 1'b0);
    check("reset_mac", mac_o[0], DEF_MAC);
    cycle(0, 1, 48'h001CC0A213DD, 32'hC0A80132);
    cycle(0, 1, 48'h001CC0A213DD, 32'hC0A80132);
    check("e0p1_locked", lock_o[1], 1'b0);
    cycle(0, 1, 48'h001CC0A213DD, 32'hC0A80132);
    check("mcu_mac", mac_o[1], 48'h001CC0A213DD);
    check("mcu_ip", ip_o[1], 32'hC0A80132);
    check("mcu_static", stat_o[1], 1'b1);
    check("mcu_locked", lock_o[1], 1'b1);
    check("mcu_flags", {macf_o[1], ipf_o[1], timed_o[1]}, 3'b110);

    // Timeout exactly 16 edges after reset release.
    cycle(1, 0, 48'd0, 32'd0);
    idle(15);
    check("to_before", lock_o[0], 1'b0);
    idle(1);
    check("to_locked", lock_o[0], 1'b1);
    check("to_timed", timed_o[0], 1'b1);
    check("to_mac", mac_o[0], DEF_MAC);
    check("to_static", stat_o[0], 1'b0);
    idle(40);
    check("no_to_locked", lock_o[1], 1'b0);

    // addr_read at the terminal edge beats the timeout.
    cycle(1, 0, 48'd0, 32'd0);
    idle(15);
    cycle(0, 1, 48'h001CC0A213DD, 32'h0A000005);
    idle(2);
    check("prio_timed", timed_o[0], 1'b0);
    check("prio_ip", ip_o[0], 32'h0A000005);

    // Multicast MAC and loopback IP are both rejected.
    cycle(1, 0, 48'd0, 32'd0);
    cycle(0, 1, 48'h010000000001, 32'h7F000001);
    idle(2);
    check("inv_mac", mac_o[0], DEF_MAC);
    check("inv_ip", ip_o[0], DEF_IP);
    check("inv_flags", {macf_o[0], ipf_o[0], stat_o[0], lock_o[0]}, 4'b0001);

    // Late MCU update after timeout, then later input changes are ignored.
    cycle(1, 0, 48'd0, 32'd0);
    idle(16);
    cycle(0, 1, 48'h0002B3C4D5E6, 32'hAC100001);
    cycle(0, 1, 48'h0002B3C4D5E6, 32'hAC100001);
    check("late_lock_hold", lock_o[0], 1'b1);
    cycle(0, 1, 48'h0002B3C4D5E6, 32'hAC100001);
    check("late_mac", mac_o[0], 48'h0002B3C4D5E6);
    check("late_timed", timed_o[0], 1'b1);
    cycle(0, 1, 48'h00AABBCCDDEE, 32'h0B000001);
    cycle(0, 0, 48'h00AABBCCDDEE, 32'h0B000001);
    idle(3);
    check("terminal_mac", mac_o[0], 48'h0002B3C4D5E6);

    // Reset while in CHECK, then restart.
    cycle(1, 0, 48'd0, 32'd0);
    cycle(0, 1, 48'h001CC0A213DD, 32'hC0A80132);
    cycle(0, 1, 48'h001CC0A213DD, 32'hC0A80132);
    cycle(1, 1, 48'h001CC0A213DD, 32'hC0A80132);
    check("chk_rst_locked", lock_o[1], 1'b0);
    check("chk_rst_mac", mac_o[1], DEF_MAC);
    cycle(0, 1, 48'h001CC0A213DD, 32'hC0A80132);
    idle(2);
    check("restart_locked", lock_o[1], 1'b1);

    // Randomized episodes.
    for (int ep = 0; ep < 60; ep++) begin
      cycle(1, 0, pick_mac(), pick_ip());
      for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
        cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, pick_mac(), pick_ip());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
